// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RV32I core.
// Contents:
//   XLEN     - datapath width
//   ctrl_t   - decoded control bundle carried down the pipeline
//   CTRL_NOP - all-zero control bundle used for bubbles
// The control unit and the ex_mem stage import this package as well.
package core_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic       branch;
        logic       mr;
        logic       mwrite;
        logic       alusrc;
        logic       regwr;
        logic [1:0] aluop;
        logic [1:0] mtoreg;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode and execute.
// Signals:
//   id_*     - decoded control and operands presented by the ID stage
//   ex_*     - registered copies visible to the EX stage
//   ex_valid - EX holds a real instruction
// Modports:
//   master - drives the id_* side and observes the ex_* side
//   slave  - the ID/EX register itself
interface id_ex_stage_if;
    import core_pkg::*;

    logic            id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr;
    logic [1:0]      id_aluop;
    logic [1:0]      id_mtoreg;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;

    logic            ex_valid;
    logic            ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr;
    logic [1:0]      ex_aluop;
    logic [1:0]      ex_mtoreg;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;

    modport master (
        output id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr,
               id_aluop, id_mtoreg, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
        input  ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr,
               ex_aluop, ex_mtoreg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
    );

    modport slave (
        input  id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr,
               id_aluop, id_mtoreg, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
        output ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr,
               ex_aluop, ex_mtoreg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5
    );

endinterface

// File: rtl/id_ex_stage_hazard_load_use.sv
// hazard_load_use: combinational load-use detector.
// Ports:
//   ex_valid, ex_mr, ex_rd  - instruction currently in EX
//   id_rs1, id_rs2          - source registers of the instruction in ID
//   id_alusrc, id_mwrite    - decide whether rs2 is actually read
//   flush_i, hold_i         - suppress the stall request
//   lu                      - raw hazard, used for the bubble decision
//   stall_o                 - stall request to PC and IF/ID
// Only register indices and control bits feed this logic, so there is no
// path from operand data to the stall request.
module hazard_load_use (
    input  logic       ex_valid,
    input  logic       ex_mr,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_alusrc,
    input  logic       id_mwrite,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       lu,
    output logic       stall_o
);

    logic use_rs2;

    // Stores read rs2 as store data even though the ALU takes the immediate.
    assign use_rs2 = ~id_alusrc | id_mwrite;

    // x0 is never written, so a load to x0 cannot create a dependency.
    assign lu = ex_valid & ex_mr & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (use_rs2 & (ex_rd == id_rs2)));

    // A flush kills the dependent instruction; a hold freezes upstream already.
    assign stall_o = lu & ~flush_i & ~hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32I core.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   bus         - id_* inputs and registered ex_* outputs (slave modport)
//   flush_i     - branch/jump redirect, kills the ID instruction
//   hold_i      - downstream memory stall, freezes the stage
//   stall_o     - combinational load-use stall to PC and IF/ID
//   bubble_cnt  - saturating count of bubbles inserted by flush or load-use
// Update priority per edge: flush, hold, load-use, capture.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    ctrl_t           id_ctrl;
    ctrl_t           ctrl_p1;
    logic            vld_p1;
    logic [XLEN-1:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
    logic [4:0]      rs1_p1, rs2_p1, rd_p1;
    logic [2:0]      funct3_p1;
    logic            funct7b5_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic            lu;
    logic            load_bubble;

    always_comb begin
        id_ctrl        = CTRL_NOP;
        id_ctrl.branch = bus.id_branch;
        id_ctrl.mr     = bus.id_mr;
        id_ctrl.mwrite = bus.id_mwrite;
        id_ctrl.alusrc = bus.id_alusrc;
        id_ctrl.regwr  = bus.id_regwr;
        id_ctrl.aluop  = bus.id_aluop;
        id_ctrl.mtoreg = bus.id_mtoreg;
        id_ctrl.jal    = bus.id_jal;
        id_ctrl.jalr   = bus.id_jalr;
    end

    hazard_load_use u_hazard (
        .ex_valid  (vld_p1),
        .ex_mr     (ctrl_p1.mr),
        .ex_rd     (rd_p1),
        .id_rs1    (bus.id_rs1),
        .id_rs2    (bus.id_rs2),
        .id_alusrc (bus.id_alusrc),
        .id_mwrite (bus.id_mwrite),
        .flush_i   (flush_i),
        .hold_i    (hold_i),
        .lu        (lu),
        .stall_o   (stall_o)
    );

    // Flush outranks hold; a load-use bubble only happens when not held.
    assign load_bubble = flush_i | (lu & ~hold_i);

    // ---- ID -> EX register (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_NOP;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            funct3_p1   <= '0;
            funct7b5_p1 <= 1'b0;
            cnt_p1      <= '0;
        end else if (load_bubble) begin
            // Operand fields keep stale values; only control and rd are cleared.
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_NOP;
            rd_p1   <= 5'd0;
            cnt_p1  <= sat_inc(cnt_p1);
        end else if (!hold_i) begin
            vld_p1      <= 1'b1;
            ctrl_p1     <= id_ctrl;
            pc_p1       <= bus.id_pc;
            rs1_data_p1 <= bus.id_rs1_data;
            rs2_data_p1 <= bus.id_rs2_data;
            imm_p1      <= bus.id_imm;
            rs1_p1      <= bus.id_rs1;
            rs2_p1      <= bus.id_rs2;
            rd_p1       <= bus.id_rd;
            funct3_p1   <= bus.id_funct3;
            funct7b5_p1 <= bus.id_funct7b5;
        end
    end

    assign bus.ex_valid    = vld_p1;
    assign bus.ex_branch   = ctrl_p1.branch;
    assign bus.ex_mr       = ctrl_p1.mr;
    assign bus.ex_mwrite   = ctrl_p1.mwrite;
    assign bus.ex_alusrc   = ctrl_p1.alusrc;
    assign bus.ex_regwr    = ctrl_p1.regwr;
    assign bus.ex_aluop    = ctrl_p1.aluop;
    assign bus.ex_mtoreg   = ctrl_p1.mtoreg;
    assign bus.ex_jal      = ctrl_p1.jal;
    assign bus.ex_jalr     = ctrl_p1.jalr;
    assign bus.ex_pc       = pc_p1;
    assign bus.ex_rs1_data = rs1_data_p1;
    assign bus.ex_rs2_data = rs2_data_p1;
    assign bus.ex_imm      = imm_p1;
    assign bus.ex_rs1      = rs1_p1;
    assign bus.ex_rs2      = rs2_p1;
    assign bus.ex_rd       = rd_p1;
    assign bus.ex_funct3   = funct3_p1;
    assign bus.ex_funct7b5 = funct7b5_p1;
    assign bubble_cnt      = cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed test-plan steps followed by random
// traffic, all checked against an instruction-level reference model.
module tb_id_ex_stage;
    import core_pkg::*;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
    } instr_t;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        hold_i;
    logic        stall_o;
    logic [15:0] bubble_cnt;

    id_ex_stage_if bus ();

    id_ex_stage #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush_i    (flush_i),
        .hold_i     (hold_i),
        .stall_o    (stall_o),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the instruction sitting in EX and the bubble total.
    logic   m_valid;
    instr_t m_ex;
    int     m_cnt;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t ex_obs();
        instr_t r;
        r.ctrl.branch = bus.ex_branch;
        r.ctrl.mr     = bus.ex_mr;
        r.ctrl.mwrite = bus.ex_mwrite;
        r.ctrl.alusrc = bus.ex_alusrc;
        r.ctrl.regwr  = bus.ex_regwr;
        r.ctrl.aluop  = bus.ex_aluop;
        r.ctrl.mtoreg = bus.ex_mtoreg;
        r.ctrl.jal    = bus.ex_jal;
        r.ctrl.jalr   = bus.ex_jalr;
        r.pc          = bus.ex_pc;
        r.rs1_data    = bus.ex_rs1_data;
        r.rs2_data    = bus.ex_rs2_data;
        r.imm         = bus.ex_imm;
        r.rs1         = bus.ex_rs1;
        r.rs2         = bus.ex_rs2;
        r.rd          = bus.ex_rd;
        r.funct3      = bus.ex_funct3;
        r.funct7b5    = bus.ex_funct7b5;
        return r;
    endfunction

    task automatic apply(input instr_t i);
        bus.id_branch   = i.ctrl.branch;
        bus.id_mr       = i.ctrl.mr;
        bus.id_mwrite   = i.ctrl.mwrite;
        bus.id_alusrc   = i.ctrl.alusrc;
        bus.id_regwr    = i.ctrl.regwr;
        bus.id_aluop    = i.ctrl.aluop;
        bus.id_mtoreg   = i.ctrl.mtoreg;
        bus.id_jal      = i.ctrl.jal;
        bus.id_jalr     = i.ctrl.jalr;
        bus.id_pc       = i.pc;
        bus.id_rs1_data = i.rs1_data;
        bus.id_rs2_data = i.rs2_data;
        bus.id_imm      = i.imm;
        bus.id_rs1      = i.rs1;
        bus.id_rs2      = i.rs2;
        bus.id_rd       = i.rd;
        bus.id_funct3   = i.funct3;
        bus.id_funct7b5 = i.funct7b5;
    endtask

    // Does the instruction in ID read the register a load in EX is producing?
    function automatic logic model_lu(input instr_t id);
        logic reads_rs2;
        if (!m_valid || !m_ex.ctrl.mr || m_ex.rd == 0) return 1'b0;
        reads_rs2 = !id.ctrl.alusrc || id.ctrl.mwrite;
        return (id.rs1 == m_ex.rd) || (reads_rs2 && id.rs2 == m_ex.rd);
    endfunction

    task automatic model_bubble();
        m_valid    = 1'b0;
        m_ex.ctrl  = '0;
        m_ex.rd    = 5'd0;
        m_cnt      = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ex    = '0;
        m_cnt   = 0;
    endtask

    task automatic check_ex(input string tag);
        check({tag, ".valid"}, 160'(bus.ex_valid), 160'(m_valid));
        check({tag, ".ex"},    160'(ex_obs()),     160'(m_ex));
        check({tag, ".cnt"},   160'(bubble_cnt),   160'(m_cnt));
    endtask

    // One cycle: present inputs at the falling edge, check the combinational
    // stall, advance the model across the rising edge, check the registers.
    task automatic step(input string tag, input instr_t id, input logic fl, input logic hd);
        logic lu;
        apply(id);
        flush_i = fl;
        hold_i  = hd;
        #1;
        lu = model_lu(id);
        check({tag, ".stall"}, 160'(stall_o), 160'(lu && !fl && !hd));
        if (fl)        model_bubble();
        else if (hd) begin end
        else if (lu)   model_bubble();
        else begin
            m_valid = 1'b1;
            m_ex    = id;
        end
        @(posedge clk);
        #1;
        check_ex(tag);
        @(negedge clk);
    endtask

    function automatic instr_t mk(input logic regwr, input logic mr, input logic mwrite,
                                  input logic alusrc, input logic [1:0] aluop,
                                  input logic [1:0] mtoreg,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd);
        instr_t i;
        i             = '0;
        i.ctrl.regwr  = regwr;
        i.ctrl.mr     = mr;
        i.ctrl.mwrite = mwrite;
        i.ctrl.alusrc = alusrc;
        i.ctrl.aluop  = aluop;
        i.ctrl.mtoreg = mtoreg;
        i.rs1         = rs1;
        i.rs2         = rs2;
        i.rd          = rd;
        i.pc          = $urandom;
        i.rs1_data    = $urandom;
        i.rs2_data    = $urandom;
        i.imm         = $urandom;
        i.funct3      = 3'($urandom_range(0, 7));
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i          = '0;
        i.ctrl     = ctrl_t'($urandom);
        i.ctrl.mr  = ($urandom_range(0, 1) == 1);
        i.pc       = $urandom;
        i.rs1_data = $urandom;
        i.rs2_data = $urandom;
        i.imm      = $urandom;
        i.rs1      = 5'($urandom_range(0, 4));
        i.rs2      = 5'($urandom_range(0, 4));
        i.rd       = 5'($urandom_range(0, 4));
        i.funct3   = 3'($urandom_range(0, 7));
        i.funct7b5 = 1'($urandom_range(0, 1));
        return i;
    endfunction

    initial begin
        instr_t add_i, lw5, add_dep, addi, sw, lw0, add0, nop;
        nop = '0;
        rst_n   = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        apply(nop);
        model_reset();
        #12;
        check("reset.stall", 160'(stall_o), 160'(0));
        check_ex("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // R-type add x3 = x1 + x2
        add_i = mk(1, 0, 0, 0, 2'b10, 2'b00, 5'd1, 5'd2, 5'd3);
        step("add", add_i, 0, 0);
        check("add.rd", 160'(bus.ex_rd), 160'(3));
        check("add.aluop", 160'(bus.ex_aluop), 160'(2'b10));

        // LW x5 then ADD x6,x5,x7: one bubble, then the ADD
        lw5     = mk(1, 1, 0, 1, 2'b00, 2'b01, 5'd2, 5'd0, 5'd5);
        add_dep = mk(1, 0, 0, 0, 2'b10, 2'b00, 5'd5, 5'd7, 5'd6);
        step("lw5", lw5, 0, 0);
        step("lu_bubble", add_dep, 0, 0);
        check("lu_bubble.regwr", 160'(bus.ex_regwr), 160'(0));
        step("lu_release", add_dep, 0, 0);
        check("lu_release.cnt", 160'(bubble_cnt), 160'(1));

        // LW x5 then ADDI x6,x0,5 (rs2 field = 5 but unused): no stall
        addi = mk(1, 0, 0, 1, 2'b00, 2'b00, 5'd0, 5'd5, 5'd6);
        step("lw5b", lw5, 0, 0);
        step("addi", addi, 0, 0);
        // LW x5 then SW x5,0(x2): rs2 is store data, stall
        sw = mk(0, 0, 1, 1, 2'b00, 2'b00, 5'd2, 5'd5, 5'd0);
        step("lw5c", lw5, 0, 0);
        step("sw_bubble", sw, 0, 0);
        step("sw_release", sw, 0, 0);

        // LW x0 then ADD x1,x0,x0: no stall
        lw0  = mk(1, 1, 0, 1, 2'b00, 2'b01, 5'd2, 5'd0, 5'd0);
        add0 = mk(1, 0, 0, 0, 2'b10, 2'b00, 5'd0, 5'd0, 5'd1);
        step("lw0", lw0, 0, 0);
        step("add0", add0, 0, 0);
        // Flush on a valid ADD
        step("flush", add_i, 1, 0);

        // Hold 3 cycles with a load in EX and a dependent in ID
        step("lw5d", lw5, 0, 0);
        for (int k = 0; k < 3; k++) step("hold", add_dep, 0, 1);
        step("hold_rel_bubble", add_dep, 0, 0);
        step("hold_rel_adv", add_dep, 0, 0);

        // Flush together with load-use
        step("lw5e", lw5, 0, 0);
        step("flush_lu", add_dep, 1, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            step("rand", rand_instr(), r < 10, (r >= 10) && (r < 25));
        end

        // Saturate the bubble counter
        flush_i = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        m_valid   = 1'b0;
        m_ex.ctrl = '0;
        m_ex.rd   = 5'd0;
        m_cnt     = 65535;
        check("sat.cnt", 160'(bubble_cnt), 160'(16'hFFFF));
        step("sat_extra", add_i, 1, 0);

        // Reset asserted in the middle of a load-use stall
        step("lw5f", lw5, 0, 0);
        apply(add_dep);
        #1;
        check("pre_rst.stall", 160'(stall_o), 160'(1));
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst.stall", 160'(stall_o), 160'(0));
        check_ex("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", add_i, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RV32I core, directly downstream of the decode control unit. Registers the decoded control bundle and operands into the EX stage, detects load-use hazards against the instruction currently in EX, and inserts bubbles on load-use, flush, or an external hold. It drives the stall request back to PC/IF-ID and keeps a saturating bubble counter for performance monitoring.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, bubble counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr  in  1 each  control from decode
- id_aluop  in  2  ALU op class
- id_mtoreg  in  2  writeback select
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode operands
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3; id_funct7b5  in  1  ALU-control fields
- flush_i  in  1  branch/jump redirect, kill the ID instruction
- hold_i  in  1  downstream memory stall, freeze the stage
- stall_o  out  1  combinational load-use stall to PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_* (all id_* fields above, same widths)  out  registered copies
- bubble_cnt  out  CNT_W  saturating bubble count

## Operation
- Load-use hazard: `lu = ex_valid & ex_mr & (ex_rd != 0) & ((ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2))`, where `use_rs2 = ~id_alusrc | id_mwrite`.
- `stall_o = lu & ~flush_i & ~hold_i`.
- Per-edge update priority, highest first:
  1. flush_i: load a bubble.
  2. hold_i: retain every ex_* register.
  3. lu: load a bubble.
  4. Otherwise: capture all id_* fields and set ex_valid=1.
- Bubble definition:
  - ex_valid=0.
  - All control outputs 0: branch, mr, mwrite, alusrc, regwr, jal, jalr, aluop=00, mtoreg=00.
  - Data and index fields may keep stale values, but ex_rd is forced to 0.
- Control fields arriving as X (store/branch mtoreg, jal/lui aluop) are captured as-is when valid. They are forced to 0 in bubbles.
- bubble_cnt increments by 1 on every edge that loads a bubble because of flush or lu. It holds at 2^CNT_W−1 and does not wrap. A held edge does not count.

## Timing
- Reset (rst_n low, asynchronous): every ex_* output is 0, ex_valid=0, bubble_cnt=0. stall_o is 0 because ex_valid=0.
- Latency: id_* at edge N appears on ex_* after edge N, one cycle.
- stall_o has zero latency: it is combinational from ex_* and id_rs*, with no combinational path from id_* data.
- Load-use costs exactly one bubble. On the next cycle ex_mr=0, so stall_o drops and the held instruction advances.
- hold_i and lu together: the stage freezes, stall_o=0, and hold_i is expected to freeze upstream too. After release, lu is re-evaluated.
- flush_i and lu together: bubble, stall_o=0, count +1.
- ex_rd=0 never raises a hazard.
- Reset asserted mid-stall clears everything. The first instruction after release captures normally.

## Structure
- Shared package `core_pkg`:
  - XLEN.
  - ctrl_t packed struct {branch, mr, mwrite, alusrc, regwr, aluop[1:0], mtoreg[1:0], jal, jalr}.
  - CTRL_NOP constant of all zeros.
- The package is also imported by the control unit and ex_mem stage.
- One sub-module: `hazard_load_use`, the combinational lu/stall_o logic. It will be reused by a future forwarding unit.
- Registers, priority mux and counter live in `id_ex_stage`.

## Test plan
- Reset then R-type add (rs1=1, rs2=2, rd=3, regwr=1, aluop=10): after 1 edge ex_valid=1, ex_rd=3, ex_aluop=10, stall_o=0.
- LW x5 then ADD x6,x5,x7: stall_o=1 for exactly one cycle, then ex_* shows a bubble (ex_regwr=0, ex_rd=0). On the next edge the ADD appears and bubble_cnt=1.
- LW x5 then ADDI x6,x0,5 with id_rs2=5 (alusrc=1, mwrite=0): no stall. LW x5 then SW x5,0(x2): stall.
- LW x0 then ADD x1,x0,x0: no stall. Flush on a valid ADD: next ex_valid=0, all ex control 0, bubble_cnt+1.
- hold_i=1 for 3 cycles holding a valid LW with a dependent instruction in ID: ex_* unchanged, stall_o=0, bubble_cnt unchanged. After release, exactly one load-use bubble follows.
- Force bubble_cnt to 0xFFFF via 65535 flushes, then flush once more: the count stays 0xFFFF. Reset mid-hazard: all outputs 0 asynchronously.
